// File: rtl/iq_select_request.sv
// Issue-queue readiness tracker: per-entry valid/ready state, tag wakeup, request generation
// for the select encoder, grant consumption and a registered issue index.
module iq_select_request #(
    parameter int unsigned IQ_SIZE      = 32,
    parameter int unsigned IQ_IDX_W     = $clog2(IQ_SIZE),
    parameter int unsigned TAG_W        = 7,
    parameter int unsigned WAKEUP_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic                            dispatch_valid_i,
    input  logic [IQ_IDX_W-1:0]             dispatch_idx_i,
    input  logic [TAG_W-1:0]                dispatch_src1_tag_i,
    input  logic                            dispatch_src1_rdy_i,
    input  logic [TAG_W-1:0]                dispatch_src2_tag_i,
    input  logic                            dispatch_src2_rdy_i,
    input  logic [WAKEUP_PORTS-1:0]         wakeup_valid_i,
    input  logic [WAKEUP_PORTS*TAG_W-1:0]   wakeup_tag_i,
    input  logic [IQ_SIZE-1:0]              grant_i,
    output logic [IQ_SIZE-1:0]              request_o,
    output logic [IQ_SIZE-1:0]              free_o,
    output logic [IQ_IDX_W:0]               free_cnt_o,
    output logic                            issue_valid_o,
    output logic [IQ_IDX_W-1:0]             issue_idx_o,
    output logic                            err_o
);

    localparam int unsigned CNT_W = IQ_IDX_W + 1;

    logic [IQ_SIZE-1:0]  valid_q, src1_rdy_q, src2_rdy_q;
    logic [IQ_SIZE-1:0]  valid_d, src1_rdy_d, src2_rdy_d;
    logic [TAG_W-1:0]    src1_tag_q [IQ_SIZE];
    logic [TAG_W-1:0]    src2_tag_q [IQ_SIZE];
    logic                issue_valid_q;
    logic [IQ_IDX_W-1:0] issue_idx_q;
    logic                err_q;

    logic                grant_multi, grant_legal, grant_illegal;
    logic [IQ_IDX_W-1:0] grant_idx;
    logic [IQ_SIZE-1:0]  grant_free;
    logic                disp_accept, disp_err, disp_src1_rdy, disp_src2_rdy;
    logic                tag_we;

    // True when any valid wakeup port broadcasts the given tag
    function automatic logic tag_hit(input logic [TAG_W-1:0]              tag,
                                     input logic [WAKEUP_PORTS-1:0]       wv,
                                     input logic [WAKEUP_PORTS*TAG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < int'(WAKEUP_PORTS); p++) begin
            if (wv[p] && (wt[p*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign request_o     = valid_q & src1_rdy_q & src2_rdy_q;
    assign free_o        = ~valid_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_idx_o   = issue_idx_q;
    assign err_o         = err_q;

    always_comb begin
        free_cnt_o = '0;
        for (int unsigned i = 0; i < IQ_SIZE; i++) begin
            free_cnt_o = free_cnt_o + CNT_W'(free_o[i]);
        end
    end

    // Grant is legal only if it is one-hot and lands on a requesting entry
    assign grant_multi   = |(grant_i & (grant_i - IQ_SIZE'(1)));
    assign grant_legal   = (|grant_i) && !grant_multi && ((grant_i & ~request_o) == '0);
    assign grant_illegal = (|grant_i) && !grant_legal;
    assign grant_free    = grant_legal ? grant_i : '0;

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < IQ_SIZE; i++) begin
            if (grant_i[i]) begin
                grant_idx = IQ_IDX_W'(i);
            end
        end
    end

    // An occupied target is only writable when it is being freed this same cycle
    assign disp_accept   = dispatch_valid_i &&
                           (!valid_q[dispatch_idx_i] || grant_free[dispatch_idx_i]);
    assign disp_err      = dispatch_valid_i && !disp_accept;
    assign disp_src1_rdy = dispatch_src1_rdy_i |
                           tag_hit(dispatch_src1_tag_i, wakeup_valid_i, wakeup_tag_i);
    assign disp_src2_rdy = dispatch_src2_rdy_i |
                           tag_hit(dispatch_src2_tag_i, wakeup_valid_i, wakeup_tag_i);
    assign tag_we        = disp_accept && !flush_i;

    always_comb begin
        valid_d    = valid_q & ~grant_free;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        for (int unsigned i = 0; i < IQ_SIZE; i++) begin
            if (valid_q[i]) begin
                src1_rdy_d[i] = src1_rdy_q[i] | tag_hit(src1_tag_q[i], wakeup_valid_i, wakeup_tag_i);
                src2_rdy_d[i] = src2_rdy_q[i] | tag_hit(src2_tag_q[i], wakeup_valid_i, wakeup_tag_i);
            end
        end
        if (disp_accept) begin
            valid_d[dispatch_idx_i]    = 1'b1;
            src1_rdy_d[dispatch_idx_i] = disp_src1_rdy;
            src2_rdy_d[dispatch_idx_i] = disp_src2_rdy;
        end
        if (flush_i) begin
            valid_d    = '0;
            src1_rdy_d = '0;
            src2_rdy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            src1_rdy_q    <= '0;
            src2_rdy_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            err_q         <= 1'b0;
            for (int unsigned i = 0; i < IQ_SIZE; i++) begin
                src1_tag_q[i] <= '0;
                src2_tag_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            err_q      <= err_q | grant_illegal | disp_err;
            for (int unsigned i = 0; i < IQ_SIZE; i++) begin
                if (tag_we && (dispatch_idx_i == IQ_IDX_W'(i))) begin
                    src1_tag_q[i] <= dispatch_src1_tag_i;
                    src2_tag_q[i] <= dispatch_src2_tag_i;
                end
            end
            if (flush_i) begin
                issue_valid_q <= 1'b0;
            end else begin
                issue_valid_q <= grant_legal;
                if (grant_legal) begin
                    issue_idx_q <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_select_request.sv
// Randomised bench for iq_select_request against a behavioural entry-table model,
// with directed scenarios pinned by hand-computed expectations.
module tb_iq_select_request;

    localparam int N  = 32;
    localparam int IW = 5;
    localparam int TW = 7;
    localparam int WP = 2;

    logic              clk, reset, flush_i;
    logic              dispatch_valid_i;
    logic [IW-1:0]     dispatch_idx_i;
    logic [TW-1:0]     dispatch_src1_tag_i, dispatch_src2_tag_i;
    logic              dispatch_src1_rdy_i, dispatch_src2_rdy_i;
    logic [WP-1:0]     wakeup_valid_i;
    logic [WP*TW-1:0]  wakeup_tag_i;
    logic [N-1:0]      grant_i;
    logic [N-1:0]      request_o, free_o;
    logic [IW:0]       free_cnt_o;
    logic              issue_valid_o;
    logic [IW-1:0]     issue_idx_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    iq_select_request #(.IQ_SIZE(N), .IQ_IDX_W(IW), .TAG_W(TW), .WAKEUP_PORTS(WP)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_idx_i(dispatch_idx_i),
        .dispatch_src1_tag_i(dispatch_src1_tag_i), .dispatch_src1_rdy_i(dispatch_src1_rdy_i),
        .dispatch_src2_tag_i(dispatch_src2_tag_i), .dispatch_src2_rdy_i(dispatch_src2_rdy_i),
        .wakeup_valid_i(wakeup_valid_i), .wakeup_tag_i(wakeup_tag_i), .grant_i(grant_i),
        .request_o(request_o), .free_o(free_o), .free_cnt_o(free_cnt_o),
        .issue_valid_o(issue_valid_o), .issue_idx_o(issue_idx_o), .err_o(err_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: a table of entries plus the issue/err registers
    bit       m_v [N];
    bit       m_r1[N];
    bit       m_r2[N];
    bit [6:0] m_t1[N];
    bit [6:0] m_t2[N];
    bit       m_iv;
    int       m_idx;
    bit       m_err;

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
        return r;
    endfunction

    function automatic logic [N-1:0] m_free();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = !m_v[i];
        return f;
    endfunction

    function automatic int m_free_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_v[i]) c++;
        return c;
    endfunction

    function automatic bit wake(bit [6:0] t);
        for (int p = 0; p < WP; p++)
            if (wakeup_valid_i[p] && wakeup_tag_i[p*TW +: TW] == t) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
        end
        m_iv = 0; m_idx = 0; m_err = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] req;
        bit legal, illegal, vold[N];
        int gidx, di;
        req     = m_req();
        legal   = ($countones(grant_i) == 1) && ((grant_i & ~req) == '0);
        illegal = (grant_i != '0) && !legal;
        gidx = -1;
        for (int i = 0; i < N; i++) if (grant_i[i]) gidx = i;
        for (int i = 0; i < N; i++) vold[i] = m_v[i];
        di = int'(dispatch_idx_i);
        if (illegal) m_err = 1;
        if (dispatch_valid_i && vold[di] && !(legal && gidx == di)) m_err = 1;
        if (flush_i) begin
            for (int i = 0; i < N; i++) begin m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; end
            m_iv = 0;
        end else begin
            for (int i = 0; i < N; i++) if (vold[i]) begin
                if (wake(m_t1[i])) m_r1[i] = 1;
                if (wake(m_t2[i])) m_r2[i] = 1;
            end
            if (legal) m_v[gidx] = 0;
            if (dispatch_valid_i && (!vold[di] || (legal && gidx == di))) begin
                m_v[di]  = 1;
                m_t1[di] = dispatch_src1_tag_i;
                m_t2[di] = dispatch_src2_tag_i;
                m_r1[di] = dispatch_src1_rdy_i || wake(dispatch_src1_tag_i);
                m_r2[di] = dispatch_src2_rdy_i || wake(dispatch_src2_tag_i);
            end
            m_iv = legal;
            if (legal) m_idx = gidx;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("request_o", 64'(request_o), 64'(m_req()));
            chk("free_o", 64'(free_o), 64'(m_free()));
            chk("free_cnt_o", 64'(free_cnt_o), 64'(m_free_count()));
            chk("issue_valid_o", 64'(issue_valid_o), 64'(m_iv));
            chk("issue_idx_o", 64'(issue_idx_o), 64'(m_idx));
            chk("err_o", 64'(err_o), 64'(m_err));
        end
    end

    task automatic idle();
        flush_i = 0; dispatch_valid_i = 0; dispatch_idx_i = '0;
        dispatch_src1_tag_i = '0; dispatch_src1_rdy_i = 0;
        dispatch_src2_tag_i = '0; dispatch_src2_rdy_i = 0;
        wakeup_valid_i = '0; wakeup_tag_i = '0; grant_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic disp(int idx, int t1, bit r1, int t2, bit r2);
        dispatch_valid_i = 1; dispatch_idx_i = IW'(idx);
        dispatch_src1_tag_i = TW'(t1); dispatch_src1_rdy_i = r1;
        dispatch_src2_tag_i = TW'(t2); dispatch_src2_rdy_i = r2;
    endtask

    task automatic mid_reset();
        idle();
        #2 reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic random_cycle();
        int q[$];
        logic [N-1:0] req;
        int r, gi;
        idle();
        flush_i = ($urandom_range(0, 99) < 2);
        req = m_req();
        gi = -1;
        r = $urandom_range(0, 99);
        if (r < 60 && req != '0) begin
            for (int i = 0; i < N; i++) if (req[i]) q.push_back(i);
            gi = q[$urandom_range(0, q.size() - 1)];
            grant_i = N'(1) << gi;
        end else if (r < 62 && !flush_i) begin
            grant_i = N'($urandom());
        end
        q.delete();
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < N; i++) if (!m_v[i]) q.push_back(i);
            if (gi >= 0 && $urandom_range(0, 3) == 0)
                disp(gi, $urandom_range(0, 15), $urandom_range(0, 2) == 0,
                     $urandom_range(0, 15), $urandom_range(0, 2) == 0);
            else if (!flush_i && $urandom_range(0, 99) < 4)
                disp($urandom_range(0, N - 1), $urandom_range(0, 15), 1, $urandom_range(0, 15), 1);
            else if (q.size() > 0)
                disp(q[$urandom_range(0, q.size() - 1)], $urandom_range(0, 15),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 2) == 0);
        end
        wakeup_valid_i = WP'($urandom_range(0, 3));
        wakeup_tag_i   = {TW'($urandom_range(0, 15)), TW'($urandom_range(0, 15))};
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
        chk_en = 1;

        // Reset state
        chk("t1_request", 64'(request_o), 64'h0);
        chk("t1_free", 64'(free_o), 64'hFFFF_FFFF);
        chk("t1_free_cnt", 64'(free_cnt_o), 64'd32);
        chk("t1_issue_valid", 64'(issue_valid_o), 64'd0);
        chk("t1_err", 64'(err_o), 64'd0);

        // Late wakeup on port 1
        disp(5, 'h12, 0, 0, 1); tick(); idle();
        chk("t2_req5_after_disp", 64'(request_o[5]), 64'd0);
        chk("t2_free_cnt", 64'(free_cnt_o), 64'd31);
        tick();
        wakeup_valid_i = 2'b10; wakeup_tag_i = {7'h12, 7'h00};
        chk("t2_req5_before_wake", 64'(request_o[5]), 64'd0);
        tick(); idle();
        chk("t2_req5_after_wake", 64'(request_o[5]), 64'd1);

        // Dispatch-cycle wakeup bypass
        disp(3, 'h40, 0, 0, 1);
        wakeup_valid_i = 2'b01; wakeup_tag_i = {7'h00, 7'h40};
        tick(); idle();
        chk("t3_req3", 64'(request_o[3]), 64'd1);

        // Legal grant
        disp(2, 1, 1, 2, 1); tick();
        disp(9, 3, 1, 4, 1); tick(); idle();
        chk("t4_request_before", 64'(request_o), 64'h22C);
        grant_i = 32'h200; tick(); idle();
        chk("t4_issue_valid", 64'(issue_valid_o), 64'd1);
        chk("t4_issue_idx", 64'(issue_idx_o), 64'd9);
        chk("t4_req9", 64'(request_o[9]), 64'd0);
        chk("t4_free9", 64'(free_o[9]), 64'd1);
        chk("t4_req2", 64'(request_o[2]), 64'd1);

        // Multi-hot grant, then dispatch onto a busy entry
        grant_i = 32'h204; tick(); idle();
        chk("t5_issue_valid", 64'(issue_valid_o), 64'd0);
        chk("t5_issue_idx_hold", 64'(issue_idx_o), 64'd9);
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_request", 64'(request_o), 64'h2C);
        tick();
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        disp(2, 'h55, 0, 'h56, 0); tick(); idle();
        chk("t5_req2_unchanged", 64'(request_o[2]), 64'd1);
        chk("t5_err_again", 64'(err_o), 64'd1);

        // Flush overrides dispatch and grant
        flush_i = 1; disp(10, 0, 1, 0, 1); grant_i = 32'h4; tick(); idle();
        chk("t6_request", 64'(request_o), 64'h0);
        chk("t6_free_cnt", 64'(free_cnt_o), 64'd32);
        chk("t6_issue_valid", 64'(issue_valid_o), 64'd0);
        chk("t6_err_kept", 64'(err_o), 64'd1);

        // Asynchronous reset in the middle of a wakeup
        disp(4, 0, 1, 'h33, 0); tick(); idle();
        disp(7, 1, 1, 1, 1); tick(); idle();
        grant_i = 32'h80;
        wakeup_valid_i = 2'b01; wakeup_tag_i = {7'h00, 7'h33};
        #1 reset = 1;
        model_reset();
        #1;
        chk("t6r_request", 64'(request_o), 64'h0);
        chk("t6r_free", 64'(free_o), 64'hFFFF_FFFF);
        chk("t6r_free_cnt", 64'(free_cnt_o), 64'd32);
        chk("t6r_issue_valid", 64'(issue_valid_o), 64'd0);
        chk("t6r_issue_idx", 64'(issue_idx_o), 64'd0);
        chk("t6r_err", 64'(err_o), 64'd0);
        idle();
        @(negedge clk);
        reset = 0;
        tick();
        chk("t6r_no_issue_after_reset", 64'(issue_valid_o), 64'd0);

        // Randomised traffic with periodic mid-run resets
        for (int c = 0; c < 3000; c++) begin
            random_cycle();
            if (c % 700 == 699) mid_reset();
        end

        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
